multimode_pulse_timer: RTL and testbench
========================================

# multimode_pulse_timer

Parametrised successor to the fixed-duration 555-style timer. It generates a digital pulse train (astable) or single pulses (monostable). High and low durations are runtime-programmable, the counter width is configurable, and completion status is reported. It sits between the lab clock source and downstream blinkers and debounced-trigger consumers as a reusable timebase.

## Interface
- WIDTH, 16, bit width of duration registers and phase counter
- DEFAULT_HIGH, 13, high-phase length in cycles after reset (matches 0.693·(R1+R2)·C for 1,1,10)
- DEFAULT_LOW, 6, low-phase length in cycles after reset (0.693·R2·C)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- enable  in  1  run gate; low forces IDLE
- mode  in  1  0 = astable, 1 = monostable
- trigger  in  1  monostable start; rising edge detected internally
- load  in  1  one-cycle strobe, captures high_cnt/low_cnt into shadow registers
- high_cnt  in  WIDTH  requested high-phase length in cycles
- low_cnt  in  WIDTH  requested low-phase length in cycles
- pulse  out  1  timer output, registered
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle strobe at end of each astable period / monostable pulse

## Operation
- States: IDLE, HIGH, LOW. pulse = 1 only in HIGH. busy = (state ≠ IDLE).
- Shadow regs sh_high/sh_low are written by load. Active regs act_high/act_low are copied from shadow on every entry to HIGH. If load coincides with that edge, the new inputs bypass into the active regs.
- A duration of 0 is treated as 1. Durations are unsigned WIDTH-bit; the maximum is 2^WIDTH−1 cycles.
- Phase counter starts at 1 on phase entry, increments per cycle, and ends the phase when it equals the active value. The counter never wraps.
- IDLE→HIGH: when mode=0 and enable=1; or when mode=1, enable=1, and a trigger rising edge occurs.
- HIGH→LOW: in astable, at count == act_high.
- HIGH→IDLE: in monostable, at count == act_high. done strobes on this edge.
- LOW→HIGH: at count == act_low, if mode=0 and enable=1. done strobes. Otherwise LOW→IDLE, and done still strobes.
- mode is sampled only in IDLE and at the end of LOW. A mid-phase change has no effect until then.
- enable=0 in any state → IDLE on the next edge; pulse=0; no done.
- Trigger edges during HIGH in monostable are ignored (see Configuration).

## Timing
- Reset (reset=0 at an edge): state=IDLE, pulse=0, busy=0, done=0, counter=0, sh/act high=DEFAULT_HIGH, sh/act low=DEFAULT_LOW, trigger history=0.
- Reset has priority over all inputs. Reset mid-phase aborts with no done.
- Astable: enable sampled high at edge n → pulse=1 after edge n for exactly act_high cycles, then 0 for act_low cycles. Period = act_high + act_low with no dead cycle.
- Monostable: a trigger rising edge is registered and detected at edge n, when trigger=1 and trigger_d=0. pulse=1 after edge n for exactly act_high cycles. Latency from trigger high to pulse high is 1 cycle.
- done is asserted for the cycle after the final edge of the phase, coincident with the first cycle of the next phase or of IDLE.

## Configuration
- MULTIMODE_PULSE_TIMER_RETRIGGER_EN
  - Defined: in monostable, a trigger rising edge during HIGH restarts the counter at 1 and reloads act_high from shadow, extending the pulse. No done is emitted for the cut-short pulse.
  - Undefined: the trigger is ignored during HIGH and the retrigger logic is absent.

## Structure
- Package multimode_pulse_timer_pkg holds the state enum (IDLE, HIGH, LOW) and the mode constants MODE_ASTABLE=0 and MODE_MONOSTABLE=1.
- Sub-module timer_phase_counter handles WIDTH-bit counting.
  - Inputs: clear, enable, terminal value.
  - Output: terminal hit.
- The top level holds the FSM, shadow/active registers, and trigger edge detection.

## Test plan
- Reset defaults: hold reset=0 for 3 cycles, then set enable=1, mode=0 → pulse high 13 cycles, low 6, repeating; done every 19 cycles.
- Reprogram: high_cnt=3, low_cnt=2, load mid-HIGH → current period unchanged; next period is 3 high / 2 low.
- Zero duration: high_cnt=0, low_cnt=0, load → pulse alternates 1 cycle high / 1 cycle low.
- Monostable: mode=1, high_cnt=5; raise trigger and hold it high 20 cycles → exactly one 5-cycle pulse starting 1 cycle after the trigger rise; done once; busy=0 afterwards.
- Abort: astable, drop enable at cycle 4 of HIGH → pulse=0 and busy=0 after next edge, no done. Repeat with reset=0 mid-LOW → same behaviour, and registers return to defaults.
- Retrigger (macro defined): mode=1, high_cnt=8, second trigger edge at cycle 5 → pulse lasts 13 cycles total and a single done. With the macro undefined → pulse lasts 8 cycles.

Source files
------------

// File: rtl/multimode_pulse_timer_pkg.sv
// Shared types for the multimode pulse timer: FSM state encoding and mode constants.
package multimode_pulse_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    localparam logic MODE_ASTABLE    = 1'b0;
    localparam logic MODE_MONOSTABLE = 1'b1;

endpackage

// File: rtl/multimode_pulse_timer_if.sv
// Control/status bundle between a timer client and multimode_pulse_timer.
interface multimode_pulse_timer_if #(
    parameter int WIDTH = 16
);
    // No valid/ready pairing: load is a one-cycle strobe accepted unconditionally,
    // enable/mode/trigger are levels, and pulse/busy/done are registered status.
    logic             enable;
    logic             mode;
    logic             trigger;
    logic             load;
    logic [WIDTH-1:0] high_cnt;
    logic [WIDTH-1:0] low_cnt;
    logic             pulse;
    logic             busy;
    logic             done;

    modport master (
        output enable, mode, trigger, load, high_cnt, low_cnt,
        input  pulse, busy, done
    );

    modport slave (
        input  enable, mode, trigger, load, high_cnt, low_cnt,
        output pulse, busy, done
    );

endinterface

// File: rtl/multimode_pulse_timer_phase_counter.sv
// timer_phase_counter: WIDTH-bit phase counter, loads 1 on clear and saturates at its terminal value.
module timer_phase_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] term,
    output logic             hit
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] term_eff;

    always_comb begin
        // A zero duration behaves as a one-cycle phase.
        term_eff = (term == '0) ? ONE : term;
        hit      = (cnt_q == term_eff);
        cnt_d    = cnt_q;
        if (clear) begin
            cnt_d = ONE;
        end else if (enable && !hit) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multimode_pulse_timer.sv
// Astable/monostable pulse timer with programmable high/low phases.
// Optional MULTIMODE_PULSE_TIMER_RETRIGGER_EN: monostable trigger during HIGH restarts the pulse.
module multimode_pulse_timer
    import multimode_pulse_timer_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int DEFAULT_HIGH = 13,
    parameter int DEFAULT_LOW  = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    multimode_pulse_timer_if.slave        bus,
    output state_e                        dbg_state
);

    localparam logic [WIDTH-1:0] DEF_HIGH = WIDTH'(DEFAULT_HIGH);
    localparam logic [WIDTH-1:0] DEF_LOW  = WIDTH'(DEFAULT_LOW);

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic             trig_d_q, trig_d_d;
    logic [WIDTH-1:0] sh_high_q, sh_high_d, sh_low_q, sh_low_d;
    logic [WIDTH-1:0] act_high_q, act_high_d, act_low_q, act_low_d;
    logic             pulse_q, pulse_d, busy_q, busy_d, done_q, done_d;

    logic             trig_rise;
    logic [WIDTH-1:0] new_high, new_low;
    logic             cnt_clear, cnt_en, cnt_hit;
    logic [WIDTH-1:0] cnt_term;

    timer_phase_counter #(.WIDTH(WIDTH)) u_phase_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .term   (cnt_term),
        .hit    (cnt_hit)
    );

    always_comb begin
        trig_rise  = bus.trigger && !trig_d_q;
        // Values copied into the active regs on HIGH entry; a coincident load bypasses the shadow.
        new_high   = bus.load ? bus.high_cnt : sh_high_q;
        new_low    = bus.load ? bus.low_cnt  : sh_low_q;
        cnt_term   = (state_q == LOW) ? act_low_q : act_high_q;

        state_d    = state_q;
        mode_d     = mode_q;
        trig_d_d   = bus.trigger;
        sh_high_d  = new_high;
        sh_low_d   = new_low;
        act_high_d = act_high_q;
        act_low_d  = act_low_q;
        done_d     = 1'b0;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.enable && (bus.mode == MODE_ASTABLE || trig_rise)) begin
                    state_d    = HIGH;
                    mode_d     = bus.mode;
                    cnt_clear  = 1'b1;
                    act_high_d = new_high;
                    act_low_d  = new_low;
                end
            end
            HIGH: begin
                if (!bus.enable) begin
                    state_d = IDLE;
`ifdef MULTIMODE_PULSE_TIMER_RETRIGGER_EN
                end else if (mode_q == MODE_MONOSTABLE && trig_rise) begin
                    cnt_clear  = 1'b1;
                    act_high_d = new_high;
                    act_low_d  = new_low;
`endif
                end else if (cnt_hit) begin
                    if (mode_q == MODE_MONOSTABLE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = LOW;
                        cnt_clear = 1'b1;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            LOW: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (cnt_hit) begin
                    done_d = 1'b1;
                    if (bus.mode == MODE_ASTABLE) begin
                        state_d    = HIGH;
                        mode_d     = MODE_ASTABLE;
                        cnt_clear  = 1'b1;
                        act_high_d = new_high;
                        act_low_d  = new_low;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        pulse_d = (state_d == HIGH);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            mode_q     <= MODE_ASTABLE;
            trig_d_q   <= 1'b0;
            sh_high_q  <= DEF_HIGH;
            sh_low_q   <= DEF_LOW;
            act_high_q <= DEF_HIGH;
            act_low_q  <= DEF_LOW;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            trig_d_q   <= trig_d_d;
            sh_high_q  <= sh_high_d;
            sh_low_q   <= sh_low_d;
            act_high_q <= act_high_d;
            act_low_q  <= act_low_d;
            pulse_q    <= pulse_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.pulse = pulse_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_multimode_pulse_timer.sv
// Directed self-checking bench for multimode_pulse_timer (astable, reprogram, zero, abort, monostable, retrigger).
module tb_multimode_pulse_timer;
    import multimode_pulse_timer_pkg::*;

    logic   clk = 1'b0;
    logic   reset;
    state_e dbg_state;
    int     total = 0;
    int     bad   = 0;
    int     exp_len;

    multimode_pulse_timer_if #(.WIDTH(16)) bus ();

    multimode_pulse_timer #(
        .WIDTH        (16),
        .DEFAULT_HIGH (13),
        .DEFAULT_LOW  (6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One astable period: h high cycles then l low cycles; optional load strobe in HIGH cycle load_at.
    task automatic run_period(input string tag, input int h, input int l, input bit first,
                              input int load_at, input logic [15:0] nh, input logic [15:0] nl);
        for (int i = 1; i <= h; i++) begin
            tick();
            check({tag, " hi pulse"}, bus.pulse, 1);
            check({tag, " hi busy"}, bus.busy, 1);
            check({tag, " hi done"}, bus.done, 32'(i == 1 && !first));
            if (i == load_at) begin
                bus.load     = 1'b1;
                bus.high_cnt = nh;
                bus.low_cnt  = nl;
            end else begin
                bus.load = 1'b0;
            end
        end
        for (int i = 1; i <= l; i++) begin
            tick();
            bus.load = 1'b0;
            check({tag, " lo pulse"}, bus.pulse, 0);
            check({tag, " lo busy"}, bus.busy, 1);
            check({tag, " lo done"}, bus.done, 0);
        end
    endtask

    initial begin
        reset        = 1'b0;
        bus.enable   = 1'b0;
        bus.mode     = MODE_ASTABLE;
        bus.trigger  = 1'b0;
        bus.load     = 1'b0;
        bus.high_cnt = '0;
        bus.low_cnt  = '0;

        // Reset defaults
        repeat (3) tick();
        check("rst pulse", bus.pulse, 0);
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst state", 32'(dbg_state), 32'(IDLE));
        reset      = 1'b1;
        bus.enable = 1'b1;
        run_period("dflt1", 13, 6, 1'b1, 0, 16'd0, 16'd0);
        run_period("dflt2", 13, 6, 1'b0, 0, 16'd0, 16'd0);

        // Reprogram mid-HIGH: current period keeps 13/6
        run_period("reprog0", 13, 6, 1'b0, 4, 16'd3, 16'd2);
        run_period("reprog1", 3, 2, 1'b0, 0, 16'd0, 16'd0);
        run_period("reprog2", 3, 2, 1'b0, 0, 16'd0, 16'd0);

        // Zero durations behave as 1
        run_period("zero0", 3, 2, 1'b0, 1, 16'd0, 16'd0);
        for (int k = 0; k < 3; k++) run_period("zero", 1, 1, 1'b0, 0, 16'd0, 16'd0);

        // Abort by enable drop at HIGH cycle 4
        run_period("abort0", 1, 1, 1'b0, 1, 16'd6, 16'd3);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("abort hi pulse", bus.pulse, 1);
            check("abort hi done", bus.done, 32'(i == 1));
            if (i == 4) bus.enable = 1'b0;
        end
        tick();
        check("abort pulse", bus.pulse, 0);
        check("abort busy", bus.busy, 0);
        check("abort done", bus.done, 0);
        check("abort state", 32'(dbg_state), 32'(IDLE));
        tick();
        check("abort done2", bus.done, 0);

        // Abort by reset mid-LOW, then defaults return
        bus.enable = 1'b1;
        run_period("rstlow", 6, 2, 1'b1, 0, 16'd0, 16'd0);
        reset = 1'b0;
        tick();
        check("rstlow pulse", bus.pulse, 0);
        check("rstlow busy", bus.busy, 0);
        check("rstlow done", bus.done, 0);
        reset = 1'b1;
        run_period("rstdflt", 13, 6, 1'b1, 0, 16'd0, 16'd0);
        bus.enable = 1'b0;
        tick();
        check("dis busy", bus.busy, 0);
        check("dis done", bus.done, 0);

        // Monostable: one 5-cycle pulse for a long trigger
        bus.mode     = MODE_MONOSTABLE;
        bus.enable   = 1'b1;
        bus.load     = 1'b1;
        bus.high_cnt = 16'd5;
        bus.low_cnt  = 16'd2;
        tick();
        check("mono idle busy", bus.busy, 0);
        bus.load    = 1'b0;
        bus.trigger = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("mono pulse", bus.pulse, 1);
            check("mono done", bus.done, 0);
        end
        tick();
        check("mono end pulse", bus.pulse, 0);
        check("mono end busy", bus.busy, 0);
        check("mono end done", bus.done, 1);
        for (int i = 1; i <= 14; i++) begin
            tick();
            check("mono hold pulse", bus.pulse, 0);
            check("mono hold busy", bus.busy, 0);
            check("mono hold done", bus.done, 0);
        end
        bus.trigger = 1'b0;

        // Second trigger edge at HIGH cycle 5
`ifdef MULTIMODE_PULSE_TIMER_RETRIGGER_EN
        exp_len = 13;
`else
        exp_len = 8;
`endif
        bus.load     = 1'b1;
        bus.high_cnt = 16'd8;
        tick();
        bus.load    = 1'b0;
        bus.trigger = 1'b1;
        for (int i = 1; i <= exp_len; i++) begin
            tick();
            check("retrig pulse", bus.pulse, 1);
            check("retrig done", bus.done, 0);
            if (i == 1) bus.trigger = 1'b0;
            if (i == 5) bus.trigger = 1'b1;
        end
        tick();
        check("retrig end pulse", bus.pulse, 0);
        check("retrig end done", bus.done, 1);
        tick();
        check("retrig after busy", bus.busy, 0);
        check("retrig after done", bus.done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
